// File: rtl/fir_root_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fir_root_pipe
//  Brief    : TAPS-tap FIR filter with programmable coefficients, followed by
//             a bit-serial non-restoring integer square root of the result.
//  Config   : FIR_ROOT_SAT_EN - when defined, the shifted FIR sum saturates
//             to all ones instead of wrapping to its low OW bits.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_root_pipe #(
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int TAPS  = 7,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DW-1:0]     Data_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [CW-1:0]     coef_data,
    output logic [OW-1:0]     FIRout,
    output logic [OW/2-1:0]   ROOTout,
    output logic              out_valid,
    input  logic              out_ready
);

    // Full-precision accumulator width, root width, remainder width
    localparam int SW   = DW + CW + $clog2(TAPS);
    localparam int RH   = OW / 2;
    localparam int RW   = (RH + 4 > OW + 2) ? RH + 4 : OW + 2;
    localparam int CNTW = $clog2(RH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DW-1:0]   x [TAPS];
    logic [CW-1:0]   b [TAPS];
    logic [SW-1:0]   sum;
    logic [OW-1:0]   y;
    logic [OW-1:0]   fir_q;

    // Root engine: radicand shifts out two bits per step, remainder kept in
    // two's complement so its sign decides add vs. subtract next step.
    logic [OW-1:0]   rad;
    logic [RW-1:0]   rem;
    logic [RH-1:0]   root;
    logic [CNTW-1:0] cnt;
    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   rem_nxt;
    logic [RH-1:0]   root_nxt;
    logic            accept;

    assign accept = in_valid && (state == IDLE);

    // Multiply-accumulate over the sample line at full precision
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + SW'(b[i]) * SW'(x[i]);
        end
    end

`ifdef FIR_ROOT_SAT_EN
    localparam int EW = (SW > OW) ? SW : OW + 1;
    logic [EW-1:0] shifted;

    // Clamp to the largest representable output when the shifted sum overflows
    always_comb begin
        shifted = EW'(sum) >> SHIFT;
        if (|shifted[EW-1:OW]) begin
            y = '1;
        end else begin
            y = shifted[OW-1:0];
        end
    end
`else
    // Keep only the low OW bits of the shifted sum
    always_comb begin
        y = OW'(sum >> SHIFT);
    end
`endif

    // One non-restoring square-root step: bring down two radicand bits, then
    // subtract (4q+1) on a non-negative remainder or add (4q+3) on a negative one
    always_comb begin
        rem_sh   = (rem << 2) | RW'(rad[OW-1 -: 2]);
        if (rem[RW-1]) begin
            rem_nxt = rem_sh + RW'({root, 2'b11});
        end else begin
            rem_nxt = rem_sh - RW'({root, 2'b01});
        end
        root_nxt = RH'({root, ~rem_nxt[RW-1]});
    end

    // Sample line, coefficient bank, FIR result register and root engine
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                b[i] <= '0;
            end
            fir_q <= '0;
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                x[0] <= Data_i;
                for (int i = 1; i < TAPS; i++) begin
                    x[i] <= x[i-1];
                end
            end
            // Addresses at or beyond TAPS match no entry and are dropped
            for (int i = 0; i < TAPS; i++) begin
                if (coef_we && (coef_addr == 4'(i))) begin
                    b[i] <= coef_data;
                end
            end
            case (state)
                LOAD: begin
                    fir_q <= y;
                    rad   <= y;
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= CNTW'(RH);
                end
                CALC: begin
                    rad   <= rad << 2;
                    rem   <= rem_nxt;
                    root  <= root_nxt;
                    cnt   <= cnt - CNTW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = CALC;
            end
            CALC: begin
                if (cnt == CNTW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign FIRout  = fir_q;
    assign ROOTout = root;

endmodule
`default_nettype wire

// File: tb/tb_fir_root_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_root_pipe
//  Brief    : Directed self-checking bench for fir_root_pipe (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_root_pipe;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Data_i = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic [7:0] FIRout;
    logic [3:0] ROOTout;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fir_root_pipe #(
        .DW(8), .CW(8), .TAPS(7), .OW(8), .SHIFT(0)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .Data_i(Data_i), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .FIRout(FIRout), .ROOTout(ROOTout),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        @(negedge Clk);
        Rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
        @(negedge Clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge Clk);
        coef_we = 1'b0;
    endtask

    // Send one sample, measure cycles from acceptance to out_valid, collect result
    task automatic run_sample(input logic [7:0] d, output int lat,
                              output logic [7:0] f, output logic [3:0] r);
        int n;
        @(negedge Clk);
        Data_i = d; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge Clk); n++; end
        @(negedge Clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(negedge Clk); lat++; end
        if (!out_valid) lat = -1;
        f = FIRout; r = ROOTout;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (FIRout !== 8'd0) $display("FAIL reset_firout got %0d want 0", FIRout); else pass_cnt++;
        total_cnt++; if (ROOTout !== 4'd0) $display("FAIL reset_rootout got %0d want 0", ROOTout); else pass_cnt++;
    endtask

    task automatic test_basic;
        int lat; logic [7:0] f; logic [3:0] r;
        write_coef(4'd0, 8'd1);
        run_sample(8'd100, lat, f, r);
        total_cnt++; if (lat !== 6) $display("FAIL basic_latency got %0d want 6", lat); else pass_cnt++;
        total_cnt++; if (f !== 8'd100) $display("FAIL basic_fir got %0d want 100", f); else pass_cnt++;
        total_cnt++; if (r !== 4'd10) $display("FAIL basic_root got %0d want 10", r); else pass_cnt++;
    endtask

    task automatic test_impulse;
        int lat; logic [7:0] f; logic [3:0] r;
        logic [7:0] exp_f [8];
        logic [3:0] exp_r [8];
        exp_f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0};
        exp_r = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0};
        do_reset;
        for (int i = 0; i < 7; i++) write_coef(4'(i), 8'(i + 1));
        for (int k = 0; k < 8; k++) begin
            run_sample((k == 0) ? 8'd1 : 8'd0, lat, f, r);
            total_cnt++; if (f !== exp_f[k]) $display("FAIL impulse_fir[%0d] got %0d want %0d", k, f, exp_f[k]); else pass_cnt++;
            total_cnt++; if (r !== exp_r[k]) $display("FAIL impulse_root[%0d] got %0d want %0d", k, r, exp_r[k]); else pass_cnt++;
        end
    endtask

    task automatic test_saturate;
        int lat; logic [7:0] f; logic [3:0] r; logic [7:0] ef; logic [3:0] er;
`ifdef FIR_ROOT_SAT_EN
        ef = 8'd255; er = 4'd15;
`else
        ef = 8'd1; er = 4'd1;
`endif
        do_reset;
        write_coef(4'd0, 8'd255);
        run_sample(8'd255, lat, f, r);
        total_cnt++; if (f !== ef) $display("FAIL overflow_fir got %0d want %0d", f, ef); else pass_cnt++;
        total_cnt++; if (r !== er) $display("FAIL overflow_root got %0d want %0d", r, er); else pass_cnt++;
    endtask

    task automatic test_stall;
        int n; int lat; logic [7:0] f; logic [3:0] r; logic stable; logic seen;
        do_reset;
        write_coef(4'd0, 8'd1);
        @(negedge Clk);
        Data_i = 8'd100; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge Clk); n++; end
        @(negedge Clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge Clk); n++; end
        seen = out_valid;
        total_cnt++; if (seen !== 1'b1) $display("FAIL stall_reach_done got %b want 1", seen); else pass_cnt++;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || FIRout !== 8'd100 || ROOTout !== 4'd10 || in_ready !== 1'b0) stable = 1'b0;
            if (c == 3) begin Data_i = 8'd50; in_valid = 1'b1; end
            if (c == 4) in_valid = 1'b0;
            @(negedge Clk);
        end
        total_cnt++; if (stable !== 1'b1) $display("FAIL stall_stable got %b want 1", stable); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        // Output now reflects x[1]; a wrongly accepted pulse would make it 50
        write_coef(4'd0, 8'd0);
        write_coef(4'd1, 8'd1);
        run_sample(8'd7, lat, f, r);
        total_cnt++; if (f !== 8'd100) $display("FAIL stall_line_fir got %0d want 100", f); else pass_cnt++;
        total_cnt++; if (r !== 4'd10) $display("FAIL stall_line_root got %0d want 10", r); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc;
        int n; int lat; logic [7:0] f; logic [3:0] r;
        do_reset;
        write_coef(4'd0, 8'd1);
        @(negedge Clk);
        Data_i = 8'd100; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge Clk); n++; end
        @(negedge Clk);          // LOAD
        in_valid = 1'b0;
        @(negedge Clk);          // CALC cycle 1
        @(negedge Clk);          // CALC cycle 2
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (FIRout !== 8'd0) $display("FAIL midrst_firout got %0d want 0", FIRout); else pass_cnt++;
        total_cnt++; if (ROOTout !== 4'd0) $display("FAIL midrst_rootout got %0d want 0", ROOTout); else pass_cnt++;
        run_sample(8'd100, lat, f, r);
        total_cnt++; if (f !== 8'd0) $display("FAIL midrst_cleared_fir got %0d want 0", f); else pass_cnt++;
        total_cnt++; if (lat !== 6) $display("FAIL midrst_latency got %0d want 6", lat); else pass_cnt++;
    endtask

    task automatic test_bad_addr;
        int lat; logic [7:0] f; logic [3:0] r;
        do_reset;
        write_coef(4'd0, 8'd2);
        write_coef(4'd1, 8'd3);
        write_coef(4'd7, 8'd99);
        write_coef(4'd15, 8'd99);
        run_sample(8'd10, lat, f, r);
        total_cnt++; if (f !== 8'd20) $display("FAIL badaddr_fir0 got %0d want 20", f); else pass_cnt++;
        total_cnt++; if (r !== 4'd4) $display("FAIL badaddr_root0 got %0d want 4", r); else pass_cnt++;
        run_sample(8'd20, lat, f, r);
        total_cnt++; if (f !== 8'd70) $display("FAIL badaddr_fir1 got %0d want 70", f); else pass_cnt++;
        total_cnt++; if (r !== 4'd8) $display("FAIL badaddr_root1 got %0d want 8", r); else pass_cnt++;
    endtask

    task automatic test_coef_timing;
        int n; int lat; logic [7:0] f; logic [3:0] r; logic [7:0] held;
        do_reset;
        write_coef(4'd0, 8'd1);
        @(negedge Clk);
        Data_i = 8'd50; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge Clk); n++; end
        @(negedge Clk);          // LOAD: this write lands on the LOAD edge
        in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd2;
        @(negedge Clk);
        coef_we = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge Clk); n++; end
        held = FIRout;
        total_cnt++; if (held !== 8'd50) $display("FAIL coefload_fir got %0d want 50", held); else pass_cnt++;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        run_sample(8'd30, lat, f, r);
        total_cnt++; if (f !== 8'd60) $display("FAIL coefnext_fir got %0d want 60", f); else pass_cnt++;
        total_cnt++; if (r !== 4'd7) $display("FAIL coefnext_root got %0d want 7", r); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int acc [$]; logic good; int d;
        do_reset;
        write_coef(4'd0, 8'd1);
        @(negedge Clk);
        Data_i = 8'd9; in_valid = 1'b1; out_ready = 1'b1;
        good = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid && (FIRout !== 8'd9 || ROOTout !== 4'd3)) good = 1'b0;
            @(negedge Clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++; if (good !== 1'b1) $display("FAIL b2b_results got %b want 1", good); else pass_cnt++;
        for (int k = 1; k < 3; k++) begin
            d = (acc.size() > k) ? acc[k] - acc[k-1] : -1;
            total_cnt++; if (d !== 7) $display("FAIL b2b_period[%0d] got %0d want 7", k, d); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_impulse;
        test_saturate;
        test_stall;
        test_reset_mid_calc;
        test_bad_addr;
        test_coef_timing;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
